// File: rtl/fod_pkg.sv
// Shared constants and helpers for the fractional output divider (FOD).
// Phase geometry of MPDIV8 plus dither LFSR configuration.
package fod_pkg;

  localparam int PH_N     = 8;
  localparam int PH_W     = 3;
  localparam int DITH_W   = 6;
  localparam int DITH_OFS = 32;
  localparam int LFSR_W   = 9;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 9'd1;

  typedef logic [PH_W-1:0] ph_t;
  typedef logic [PH_N-1:0] ph_oh_t;

  function automatic ph_oh_t onehot8(input ph_t ph);
    ph_oh_t oh;
    oh     = '0;
    oh[ph] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fod_dith_lfsr9.sv
// 9-bit Fibonacci XNOR LFSR (x^9 + x^5 + 1) for FOD dither points.
// Seed 1; the all-ones lock state is unreachable from the seed.
module fod_dith_lfsr9
  import fod_pkg::*;
(
  input  logic              CLK,
  input  logic              ARST,
  input  logic              ADV,
  input  logic              CLR,
  output logic [DITH_W-1:0] RND6
);

  logic [LFSR_W:1] lfsr_q;
  logic [LFSR_W:1] lfsr_d;
  logic            fb;

  assign fb = ~(lfsr_q[LFSR_W] ^ lfsr_q[5]);

  always_comb begin
    lfsr_d = lfsr_q;
    if (CLR) begin
      lfsr_d = LFSR_SEED;
    end else if (ADV) begin
      lfsr_d = {lfsr_q[LFSR_W-1:1], fb};
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign RND6 = lfsr_q[DITH_W:1];

endmodule

// File: rtl/fod_phase_ctrl.sv
// FOD phase-select controller: first-order phase accumulator with
// optional LFSR dither, emitting phase index and whole-cycle count per edge.
module fod_phase_ctrl
  import fod_pkg::*;
#(
  parameter int IW       = 8,
  parameter int FW       = 16,
  parameter int MIN_STEP = 16
) (
  input  logic          CLK,
  input  logic          ARST,
  input  logic          EN,
  input  logic          DITH_EN,
  input  logic          REQ,
  input  logic [IW-1:0] FCW_I,
  input  logic [FW-1:0] FCW_F,
  output logic [2:0]    PH_SEL,
  output logic [7:0]    PH_SEL_OH,
  output logic [IW-3:0] DIV_N,
  output logic          VLD,
  output logic          ERR
);

  // Sum carries 3 extra bits so +dither on a near-full fraction cannot alias.
  localparam int SW = FW + 3;
  localparam int TW = IW + 1;

  localparam logic [IW-1:0] MIN_FI = IW'(MIN_STEP);
  localparam logic [SW-1:0] OFS    = SW'(DITH_OFS);

  logic [FW-1:0]     acc_q;
  logic [FW-1:0]     acc_d;
  ph_t               ptr_q;
  ph_t               ptr_d;
  ph_t               ph_q;
  ph_t               ph_d;
  ph_oh_t            oh_q;
  ph_oh_t            oh_d;
  logic [IW-3:0]     div_q;
  logic [IW-3:0]     div_d;
  logic              vld_q;
  logic              vld_d;
  logic              err_q;
  logic              err_d;

  logic              upd;
  logic              clamp;
  logic [IW-1:0]     fi;
  logic [DITH_W-1:0] rnd;
  logic [SW-1:0]     dith;
  logic [SW-1:0]     sum;
  logic [2:0]        c;
  logic [TW-1:0]     tot;

  assign upd   = EN & REQ;
  assign clamp = FCW_I < MIN_FI;
  assign fi    = clamp ? MIN_FI : FCW_I;

  fod_dith_lfsr9 u_lfsr (
    .CLK  (CLK),
    .ARST (ARST),
    .ADV  (upd & DITH_EN),
    .CLR  (~EN),
    .RND6 (rnd)
  );

  // Modulo-2^SW arithmetic gives the signed sum directly.
  assign dith = DITH_EN ? (SW'(rnd) - OFS) : '0;
  assign sum  = SW'(acc_q) + SW'(FCW_F) + dith;
  assign c    = sum[SW-1:FW];
  assign tot  = TW'(ptr_q) + TW'(fi) + {{(TW-3){c[2]}}, c};

  always_comb begin
    acc_d = acc_q;
    ptr_d = ptr_q;
    ph_d  = ph_q;
    oh_d  = oh_q;
    div_d = div_q;
    vld_d = 1'b0;
    err_d = err_q;
    if (!EN) begin
      acc_d = '0;
      ptr_d = '0;
      err_d = 1'b0;
    end else if (upd) begin
      acc_d = sum[FW-1:0];
      ptr_d = tot[PH_W-1:0];
      ph_d  = tot[PH_W-1:0];
      oh_d  = onehot8(tot[PH_W-1:0]);
      div_d = tot[TW-1:PH_W];
      vld_d = 1'b1;
      err_d = err_q | clamp;
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      acc_q <= '0;
      ptr_q <= '0;
      ph_q  <= '0;
      oh_q  <= 8'h01;
      div_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ptr_q <= ptr_d;
      ph_q  <= ph_d;
      oh_q  <= oh_d;
      div_q <= div_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign PH_SEL    = ph_q;
  assign PH_SEL_OH = oh_q;
  assign DIV_N     = div_q;
  assign VLD       = vld_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_fod_phase_ctrl.sv
// Bench for fod_phase_ctrl: absolute-time edge model plus directed vectors.
// The model tracks edge time T in 2^-16 phase steps; PH_SEL/DIV_N follow from floor(T).
module tb_fod_phase_ctrl;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       en = 1'b0;
  logic       dith = 1'b0;
  logic       req = 1'b0;
  logic [7:0] fcw_i = 8'd16;
  logic [15:0] fcw_f = 16'd0;

  logic [2:0] ph;
  logic [7:0] oh;
  logic [5:0] divn;
  logic       vld;
  logic       err;

  int n_chk = 0;
  int n_pass = 0;
  bit run = 1'b0;

  int oph[$];
  int odiv[$];
  int ph3[6] = '{0, 1, 1, 2, 2, 3};

  fod_phase_ctrl dut (
    .CLK       (clk),
    .ARST      (arst),
    .EN        (en),
    .DITH_EN   (dith),
    .REQ       (req),
    .FCW_I     (fcw_i),
    .FCW_F     (fcw_f),
    .PH_SEL    (ph),
    .PH_SEL_OH (oh),
    .DIV_N     (divn),
    .VLD       (vld),
    .ERR       (err)
  );

  always #5 clk = ~clk;

  longint     t_q;
  logic [8:0] ml_q;
  bit         merr_q;
  bit         mvld_q;
  int         mph_q;
  int         mdiv_q;

  function automatic int fi_cl(input int v);
    return (v < 16) ? 16 : v;
  endfunction

  function automatic logic [8:0] lfsr_nx(input logic [8:0] l);
    return {l[7:0], ~(l[8] ^ l[4])};
  endfunction

  function automatic longint t_next();
    longint d;
    d = dith ? longint'(int'(ml_q[5:0]) - 32) : 64'sd0;
    return t_q + (longint'(fi_cl(int'(fcw_i))) * 65536) + longint'(fcw_f) + d;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      t_q <= 0; ml_q <= 9'd1; merr_q <= 1'b0; mvld_q <= 1'b0;
      mph_q <= 0; mdiv_q <= 0;
    end else if (!en) begin
      t_q <= 0; ml_q <= 9'd1; merr_q <= 1'b0; mvld_q <= 1'b0;
    end else if (req) begin
      t_q <= t_next();
      mph_q <= int'((t_next() / 65536) % 8);
      mdiv_q <= int'((t_next() / 65536) / 8 - (t_q / 65536) / 8);
      if (fcw_i < 8'd16) merr_q <= 1'b1;
      if (dith) ml_q <= lfsr_nx(ml_q);
      mvld_q <= 1'b1;
    end else begin
      mvld_q <= 1'b0;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    #2;
    if (run) begin
      chk("ph_sel", longint'(ph), longint'(mph_q));
      chk("ph_oh", longint'(oh), longint'(8'd1 << mph_q));
      chk("div_n", longint'(divn), longint'(mdiv_q));
      chk("vld", longint'(vld), longint'(mvld_q));
      chk("err", longint'(err), longint'(merr_q));
      if (vld) begin
        oph.push_back(int'(ph));
        odiv.push_back(int'(divn));
      end
    end
  end

  task automatic reqs(input int n, input int fi, input int ff, input bit dt, input bit b2b);
    oph.delete();
    odiv.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fcw_i = 8'(fi); fcw_f = 16'(ff); dith = dt; req = 1'b1;
      if (!b2b) begin
        @(negedge clk);
        req = 1'b0;
      end
    end
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #3;
  endtask

  task automatic flush();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    int bad;
    int sdiv;
    repeat (2) @(negedge clk);
    run = 1'b1;
    #3;
    chk("rst_ph", longint'(ph), 0);
    chk("rst_oh", longint'(oh), 1);
    chk("rst_div", longint'(divn), 0);
    chk("rst_vld", longint'(vld), 0);
    chk("rst_err", longint'(err), 0);
    @(negedge clk);
    arst = 1'b0;
    en = 1'b1;

    reqs(8, 16, 0, 0, 0);
    chk("t1_cnt", oph.size(), 8);
    bad = 0;
    foreach (oph[i]) if (oph[i] != 0 || odiv[i] != 2) bad++;
    chk("t1_vals", bad, 0);
    chk("t1_err", longint'(err), 0);

    flush();
    reqs(9, 17, 0, 0, 1);
    chk("t2_cnt", oph.size(), 9);
    bad = 0;
    foreach (oph[i]) if (oph[i] != (i + 1) % 8 || odiv[i] != ((i == 7) ? 3 : 2)) bad++;
    chk("t2_vals", bad, 0);
    if (oph.size() == 9) chk("t2_wrap_div", odiv[7], 3);

    flush();
    reqs(6, 16, 'h8000, 0, 0);
    chk("t3_cnt", oph.size(), 6);
    bad = 0;
    foreach (oph[i]) if (i < 6 && (oph[i] != ph3[i] || odiv[i] != 2)) bad++;
    chk("t3_vals", bad, 0);

    flush();
    reqs(511, 16, 0, 1, 1);
    chk("t4_cnt", oph.size(), 511);
    bad = 0;
    sdiv = 0;
    foreach (oph[i]) begin
      if (!(oph[i] == 7 || oph[i] == 0 || oph[i] == 1)) bad++;
      sdiv += odiv[i];
    end
    chk("t4_range", bad, 0);
    chk("t4_sumdiv", sdiv, 1021);
    if (oph.size() > 0) chk("t4_last_ph", oph[oph.size() - 1], 7);

    flush();
    reqs(3, 5, 0, 0, 0);
    bad = 0;
    foreach (oph[i]) if (oph[i] != 0 || odiv[i] != 2) bad++;
    chk("t5_clamp", bad, 0);
    chk("t5_err", longint'(err), 1);
    flush();
    #3;
    chk("t5_err_clr", longint'(err), 0);
    reqs(1, 17, 0, 0, 0);
    if (oph.size() == 1) chk("t5_ptr0", oph[0], 1);
    else chk("t5_cnt", oph.size(), 1);

    oph.delete();
    @(negedge clk);
    en = 1'b0; req = 1'b1; fcw_i = 8'd20;
    @(negedge clk);
    req = 1'b0;
    #3;
    chk("t6_vld", longint'(vld), 0);
    chk("t6_cnt", oph.size(), 0);
    en = 1'b1;

    flush();
    reqs(2, 19, 0, 0, 0);
    if (oph.size() == 2) chk("t7_pre", oph[1], 6);
    else chk("t7_pre_cnt", oph.size(), 2);
    oph.delete();
    @(negedge clk);
    fcw_i = 8'd19; req = 1'b1;
    #4 arst = 1'b1;
    @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    req = 1'b0;
    #3;
    chk("t7_ph", longint'(ph), 0);
    chk("t7_oh", longint'(oh), 1);
    chk("t7_div", longint'(divn), 0);
    chk("t7_vld", longint'(vld), 0);
    chk("t7_cnt", oph.size(), 0);
    reqs(1, 19, 0, 0, 0);
    if (oph.size() == 1) begin
      chk("t7_ph_after", oph[0], 3);
      chk("t7_div_after", odiv[0], 2);
    end else begin
      chk("t7_cnt_after", oph.size(), 1);
    end

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
